// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared constants and state encoding for the bit-serial adder controller.
`default_nettype none

package serial_add_ctrl_pkg;

  localparam int SERIAL_ADD_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-counter width; floors at 1 so tiny widths still get a real register.
  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// full_adder: 1-bit full adder cell shared by the serial adder controller.
`default_nettype none

module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

`default_nettype wire

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands one bit per clock through a single full_adder.
// Optional signed-overflow output ovf when SERIAL_ADD_OVF_EN is defined.
`default_nettype none

module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_bits(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum_sh;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_cout;
  logic               w_fa_sum;
  logic               w_fa_cout;
  logic               w_last;
  logic               w_accept;
  logic [WIDTH-1:0]   w_sum_sh_nxt;

  full_adder u_fa (
    .A    (r_a[0]),
    .B    (r_b[0]),
    .Cin  (r_carry),
    .Sum  (w_fa_sum),
    .Cout (w_fa_cout)
  );

  assign w_last       = (r_cnt == C_CNT_LAST);
  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_sum_sh_nxt = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = S_IDLE;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = start ? S_RUN : S_IDLE;
      S_RUN: begin
        busy        = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_RUN;
      end
      S_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result registers load on the final RUN edge so sum/cout are already valid in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sum_sh <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_carry  <= cin;
      r_sum_sh <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_a      <= {1'b0, r_a[WIDTH-1:1]};
      r_b      <= {1'b0, r_b[WIDTH-1:1]};
      r_sum_sh <= w_sum_sh_nxt;
      r_carry  <= w_fa_cout;
      if (w_last) begin
        r_sum  <= w_sum_sh_nxt;
        r_cout <= w_fa_cout;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic r_ovf;

  // On the last bit the carry register holds the carry into the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_ovf <= r_carry ^ w_fa_cout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

`default_nettype wire
